// File: rtl/i2c_calc_engine.sv
// i2c_calc_engine
// Calculator core that sits behind the I2C target byte interface. A write
// frame (opcode, operand A, operand B, all multi-byte values MSB first)
// starts a computation; I2C reads then return a status byte followed by the
// result, MSB first.
//
// Parameters:
//   WIDTH     operand/result width in bits (multiple of 8, at least 8)
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   wr_valid  strobe: wr_data holds a received write byte
//   wr_data   received byte
//   wr_first  qualifies wr_valid: first data byte of a new write transaction
//   rd_start  strobe: read transaction begins, read pointer returns to 0
//   rd_req    strobe: current rd_data byte consumed, advance read pointer
//   rd_data   registered byte presented for the next read
//   busy      high while a computation is in progress
//   done      one-cycle pulse when a new result becomes valid
module i2c_calc_engine #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    input  logic       wr_first,
    input  logic       rd_start,
    input  logic       rd_req,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done
);

    localparam int NBYTES = WIDTH / 8;
    localparam int PW     = $clog2(NBYTES + 2);
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int IW     = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        CALC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [CW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  work_hi_q, work_hi_d;
    logic [WIDTH-1:0]  work_lo_q, work_lo_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic              div0_q, div0_d;
    logic              err_op_q, err_op_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [7:0]        rd_data_q, rd_data_d;

    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;
    logic [WIDTH:0]    mul_add;
    logic [WIDTH-1:0]  mul_hi_n;
    logic [WIDTH-1:0]  mul_lo_n;
    logic [WIDTH:0]    rem_shift;
    logic              div_ge;
    logic [WIDTH-1:0]  div_rem_n;
    logic [WIDTH-1:0]  div_quo_n;
    logic              last_iter;
    logic [7:0]        status_d;

    // Single-cycle arithmetic plus one step of the iterative multiply and
    // divide. The multiply keeps {work_hi, work_lo} as the partial product
    // with the multiplier shifting out of work_lo; the divide keeps the
    // partial remainder in work_hi and the dividend/quotient in work_lo.
    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        diff      = {1'b0, a_q} - {1'b0, b_q};
        mul_add   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, a_q} : '0);
        mul_hi_n  = mul_add[WIDTH:1];
        mul_lo_n  = {mul_add[0], work_lo_q[WIDTH-1:1]};
        rem_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_ge    = (rem_shift >= {1'b0, b_q});
        div_rem_n = div_ge ? WIDTH'(rem_shift - {1'b0, b_q})
                           : rem_shift[WIDTH-1:0];
        div_quo_n = {work_lo_q[WIDTH-2:0], div_ge};
        last_iter = (iter_q == IW'(WIDTH - 1));
    end

    // Frame reception, computation sequencing and result capture. A first
    // byte always restarts the frame, even in the middle of a computation,
    // so a stale result can never complete after a new frame has begun.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        byte_cnt_d = byte_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        work_hi_d  = work_hi_q;
        work_lo_d  = work_lo_q;
        iter_d     = iter_q;
        result_d   = result_q;
        carry_d    = carry_q;
        div0_d     = div0_q;
        err_op_d   = err_op_q;
        valid_d    = valid_q;
        done_d     = 1'b0;

        if (wr_valid && wr_first) begin
            opcode_d   = wr_data;
            byte_cnt_d = '0;
            valid_d    = 1'b0;
            err_op_d   = 1'b0;
            div0_d     = 1'b0;
            state_d    = GET_A;
        end else begin
            case (state_q)
                GET_A: begin
                    if (wr_valid) begin
                        a_d = WIDTH'({a_q, wr_data});
                        if (byte_cnt_q == CW'(NBYTES - 1)) begin
                            byte_cnt_d = '0;
                            state_d    = GET_B;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end
                GET_B: begin
                    if (wr_valid) begin
                        b_d = WIDTH'({b_q, wr_data});
                        if (byte_cnt_q == CW'(NBYTES - 1)) begin
                            // Iteration registers are primed here so the
                            // first CALC cycle already performs a real step.
                            byte_cnt_d = '0;
                            iter_d     = '0;
                            work_hi_d  = '0;
                            work_lo_d  = (opcode_q == 8'd2) ? b_d : a_q;
                            state_d    = CALC;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end
                CALC: begin
                    done_d   = 1'b1;
                    carry_d  = 1'b0;
                    div0_d   = 1'b0;
                    err_op_d = 1'b0;
                    case (opcode_q)
                        8'd0: begin
                            result_d = sum[WIDTH-1:0];
                            carry_d  = sum[WIDTH];
                        end
                        8'd1: begin
                            result_d = diff[WIDTH-1:0];
                            carry_d  = diff[WIDTH];
                        end
                        8'd2: begin
                            result_d = mul_lo_n;
                            carry_d  = |mul_hi_n;
                        end
                        8'd3, 8'd4: begin
                            if (b_q == '0) begin
                                div0_d   = 1'b1;
                                result_d = (opcode_q == 8'd3) ? '1 : a_q;
                            end else begin
                                result_d = (opcode_q == 8'd3) ? div_quo_n
                                                              : div_rem_n;
                            end
                        end
                        8'd5: result_d = a_q & b_q;
                        8'd6: result_d = a_q | b_q;
                        8'd7: result_d = a_q ^ b_q;
                        default: begin
                            result_d = '0;
                            err_op_d = 1'b1;
                        end
                    endcase

                    // Iterative operations keep stepping until their final
                    // step; a zero divisor finishes immediately.
                    if (((opcode_q == 8'd2) ||
                         (((opcode_q == 8'd3) || (opcode_q == 8'd4)) && (b_q != '0)))
                        && !last_iter) begin
                        done_d    = 1'b0;
                        result_d  = result_q;
                        carry_d   = carry_q;
                        div0_d    = div0_q;
                        err_op_d  = err_op_q;
                        iter_d    = iter_q + 1'b1;
                        work_hi_d = (opcode_q == 8'd2) ? mul_hi_n : div_rem_n;
                        work_lo_d = (opcode_q == 8'd2) ? mul_lo_n : div_quo_n;
                    end

                    if (done_d) begin
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read pointer and registered read byte. The byte is built from the
    // next-cycle state so rd_data always matches the current pointer and
    // status one cycle after any strobe.
    always_comb begin
        ptr_d = ptr_q;
        if (rd_start) begin
            ptr_d = '0;
        end else if (rd_req && (ptr_q != PW'(NBYTES + 1))) begin
            ptr_d = ptr_q + 1'b1;
        end

        status_d  = {(state_d == CALC), valid_d, 3'b000, err_op_d, div0_d, carry_d};
        rd_data_d = 8'hFF;
        if (ptr_d == '0) begin
            rd_data_d = status_d;
        end
        for (int i = 1; i <= NBYTES; i++) begin
            if (ptr_d == PW'(i)) begin
                rd_data_d = result_d[8*(NBYTES-i) +: 8];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opcode_q   <= '0;
            byte_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            work_hi_q  <= '0;
            work_lo_q  <= '0;
            iter_q     <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            div0_q     <= 1'b0;
            err_op_q   <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ptr_q      <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            byte_cnt_q <= byte_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            work_hi_q  <= work_hi_d;
            work_lo_q  <= work_lo_d;
            iter_q     <= iter_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            div0_q     <= div0_d;
            err_op_q   <= err_op_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ptr_q      <= ptr_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = done_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_i2c_calc_engine.sv
// Directed testbench for i2c_calc_engine with WIDTH=16. Expected values are
// hand-computed constants.
module tb_i2c_calc_engine;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_first;
    logic       rd_start;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;

    int testsRun;
    int failCount;

    i2c_calc_engine #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_first (wr_first),
        .rd_start (rd_start),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one write byte for one cycle; called at a falling edge.
    task automatic sendByte(input logic [7:0] b, input logic first);
        wr_valid = 1'b1;
        wr_data  = b;
        wr_first = first;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_first = 1'b0;
    endtask

    // Full write frame: opcode, A MSB first, B MSB first.
    task automatic applyStimulus(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        sendByte(op, 1'b1);
        sendByte(a[15:8], 1'b0);
        sendByte(a[7:0], 1'b0);
        sendByte(b[15:8], 1'b0);
        sendByte(b[7:0], 1'b0);
    endtask

    // Count cycles with busy high (bounded), noting whether done pulsed.
    task automatic waitDone(output int cycles, output logic doneSeen);
        cycles   = 0;
        doneSeen = 1'b0;
        while (busy && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (done) doneSeen = 1'b1;
        end
    endtask

    // rd_start then two rd_req: status, result MSB, result LSB.
    task automatic readResult(output logic [7:0] s, output logic [7:0] m, output logic [7:0] l);
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        s = rd_data;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        m = rd_data;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        l = rd_data;
    endtask

    // Run one operation and check latency, done pulse, status and result.
    task automatic runOp(input string tag, input logic [7:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int expCycles,
                         input logic [7:0] expSt, input logic [15:0] expRes);
        int cycles;
        logic doneSeen;
        logic [7:0] s, m, l;
        applyStimulus(op, a, b);
        waitDone(cycles, doneSeen);
        checkOutput({tag, "_cycles"}, cycles, expCycles);
        checkOutput({tag, "_done"}, doneSeen, 1'b1);
        readResult(s, m, l);
        checkOutput({tag, "_status"}, s, expSt);
        checkOutput({tag, "_result"}, {m, l}, expRes);
    endtask

    initial begin
        int cycles;
        int donePulses;
        logic doneSeen;
        logic [7:0] s, m, l;

        testsRun  = 0;
        failCount = 0;
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        wr_first  = 1'b0;
        rd_start  = 1'b0;
        rd_req    = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_rd_data", rd_data, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle and iterative operations.
        runOp("add",     8'h00, 16'h1234, 16'h0FFF, 1,  8'h40, 16'h2233);
        runOp("add_cy",  8'h00, 16'hFFFF, 16'h0001, 1,  8'h41, 16'h0000);
        runOp("sub",     8'h01, 16'h0001, 16'h0002, 1,  8'h41, 16'hFFFF);
        runOp("mul_ovf", 8'h02, 16'h0100, 16'h0100, 16, 8'h41, 16'h0000);
        runOp("mul",     8'h02, 16'h00FF, 16'h0002, 16, 8'h40, 16'h01FE);
        runOp("div",     8'h03, 16'h03E8, 16'h0007, 16, 8'h40, 16'h008E);
        runOp("mod",     8'h04, 16'h03E8, 16'h0007, 16, 8'h40, 16'h0006);
        runOp("and",     8'h05, 16'hF0F0, 16'h3C3C, 1,  8'h40, 16'h3030);
        runOp("xor",     8'h07, 16'hF0F0, 16'h3C3C, 1,  8'h40, 16'hCCCC);
        runOp("badop",   8'h09, 16'h1111, 16'h2222, 1,  8'h44, 16'h0000);
        runOp("div0",    8'h03, 16'h1234, 16'h0000, 1,  8'h42, 16'hFFFF);
        runOp("mod0",    8'h04, 16'h1234, 16'h0000, 1,  8'h42, 16'h1234);

        // Read during a multiply, then abort it with a new frame.
        applyStimulus(8'h02, 16'h0100, 16'h0100);
        checkOutput("calc_busy", busy, 1'b1);
        readResult(s, m, l);
        checkOutput("calc_status_bv", s[7:6], 2'b10);
        checkOutput("calc_prev_result", {m, l}, 16'h1234);
        sendByte(8'h00, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        donePulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) donePulses++;
            @(negedge clk);
        end
        checkOutput("abort_no_done", donePulses, 0);
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        checkOutput("abort_status_bv", rd_data[7:6], 2'b00);
        sendByte(8'h00, 1'b0);
        sendByte(8'h03, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'h05, 1'b0);
        waitDone(cycles, doneSeen);
        checkOutput("restart_cycles", cycles, 1);
        readResult(s, m, l);
        checkOutput("restart_status", s, 8'h40);
        checkOutput("restart_result", {m, l}, 16'h0008);

        // Asynchronous reset in the middle of a divide.
        applyStimulus(8'h03, 16'h03E8, 16'h0007);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_done", done, 1'b0);
        checkOutput("arst_rd_data", rd_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        readResult(s, m, l);
        checkOutput("arst_status", s, 8'h00);
        checkOutput("arst_result", {m, l}, 16'h0000);

        // Read pointer walk, saturation and start/req collision.
        runOp("add2", 8'h00, 16'h1234, 16'h0FFF, 1, 8'h40, 16'h2233);
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        checkOutput("ptr0", rd_data, 8'h40);
        for (int i = 1; i <= 6; i++) begin
            rd_req = 1'b1;
            @(negedge clk);
            rd_req = 1'b0;
            case (i)
                1:       checkOutput("ptr1", rd_data, 8'h22);
                2:       checkOutput("ptr2", rd_data, 8'h33);
                default: checkOutput("ptr_sat", rd_data, 8'hFF);
            endcase
        end
        rd_start = 1'b1;
        rd_req   = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        rd_req   = 1'b0;
        checkOutput("ptr_start_wins", rd_data, 8'h40);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/i2c_calc_engine.md
Name: i2c_calc_engine

Overview:
- Parametrised, multi-cycle successor to the byte-wide I2C calculator core.
- Sits behind the I2C target byte interface inside the tt_um top level.
- Consumes a write frame of opcode, operand A and operand B, then computes. Eight operations are supported, including iterative multiply/divide.
- Serves a status byte plus the result, MSB first, to I2C read transactions.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 8 and at least 8.
- NBYTES, WIDTH/8, derived localparam: bytes per operand and per result.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wr_valid  input  1  one-cycle strobe: wr_data holds a received write byte
- wr_data  input  8  received byte
- wr_first  input  1  qualifies wr_valid: byte is the first data byte of a new I2C write transaction
- rd_start  input  1  one-cycle strobe: I2C read transaction begins; read pointer resets to 0
- rd_req  input  1  one-cycle strobe: current rd_data byte was consumed; advance the pointer
- rd_data  output  8  byte presented to the I2C target for the next read
- busy  output  1  high while a computation is in progress
- done  output  1  one-cycle pulse when a result becomes valid

Behaviour:
- Reset (async, rst_n=0) clears everything:
  - FSM goes to IDLE; operands, result and flags are 0; read pointer is 0.
  - busy=0, done=0, rd_data=0x00 (status byte with valid=0).
- Frame format: opcode byte, then A (NBYTES, MSB first), then B (NBYTES, MSB first).
- FSM states: IDLE, GET_A, GET_B, CALC, DONE.
  - wr_valid&wr_first in any state: latch opcode, clear byte counter, clear valid and error flags, go to GET_A. This aborts any CALC in progress.
  - GET_A: each wr_valid shifts a byte in. After NBYTES bytes, go to GET_B.
  - GET_B: same shifting. On the last byte, enter CALC next cycle with busy=1.
  - wr_valid without wr_first in IDLE, CALC or DONE: byte is ignored.
  - CALC -> DONE when the operation completes. done pulses in the first DONE cycle; busy drops in that same cycle.
  - DONE holds until the next wr_first.
- Opcodes and latency (cycles spent in CALC):
  - 0 ADD: result=A+B mod 2^WIDTH; carry=carry-out. 1 cycle.
  - 1 SUB: result=A-B mod 2^WIDTH; carry=borrow (A<B). 1 cycle.
  - 2 MUL: iterative shift-add, unsigned, WIDTH cycles. result=low WIDTH bits; carry=1 if the high half is nonzero.
  - 3 DIV: restoring divide, unsigned, WIDTH cycles. result=quotient.
  - 4 MOD: restoring divide, unsigned, WIDTH cycles. result=remainder.
  - 5 AND, 6 OR, 7 XOR: bitwise, 1 cycle. carry=0.
  - 8..255: err_op=1, result=0, 1 cycle.
- Divide by zero (B=0, op 3/4):
  - div0=1 and the operation takes 1 cycle.
  - DIV result=all ones; MOD result=A.
- Status byte, bit by bit:
  - bit7 = busy.
  - bit6 = valid: set on entering DONE, cleared by wr_first and by reset.
  - bit5..3 = 0.
  - bit2 = err_op; bit1 = div0; bit0 = carry.
- Read side:
  - Pointer 0 selects the status byte; pointers 1..NBYTES select result bytes, MSB first.
  - A pointer beyond NBYTES returns 0xFF.
  - rd_data is a registered output: it reflects a pointer change one cycle after rd_start or rd_req.
  - The pointer saturates at NBYTES+1.
  - rd_start and rd_req in the same cycle: rd_start wins (pointer=0).
  - Reads during CALC return the status byte with busy=1, valid=0; result bytes hold the previous result.
  - Reading never disturbs the FSM, and simultaneous read and write strobes are both honoured.
- Result and flag registers update only on the CALC->DONE transition.

Test Plan (WIDTH=16):
- ADD: write 00,12,34,0F,FF -> done after 1 CALC cycle; read yields 40,22,33 (status valid, carry 0). Then ADD FFFF+0001 -> 41,00,00.
- SUB and MUL:
  - SUB: 01,00,01,00,02 -> read 41,FF,FF.
  - MUL: 02,01,00,01,00 -> busy for exactly 16 cycles, then read 41,00,00 (overflow).
  - MUL: 02,00,FF,00,02 -> 40,01,FE.
- DIV/MOD:
  - 03,03,E8,00,07 (1000/7) -> 40,00,8E.
  - 04 with the same operands -> 40,00,06.
- Divide by zero and bad opcode:
  - 03,12,34,00,00 -> 42,FF,FF after 1 cycle.
  - 04,12,34,00,00 -> 42,12,34.
  - Opcode 09 -> 44,00,00.
- Abort/reset:
  - A new wr_first mid-MUL restarts the frame: the old done never pulses, and status reads valid=0.
  - rst_n pulsed low mid-DIV: busy=0 immediately (asynchronously); status 0x00.
- Read pointer:
  - Four rd_req after rd_start give status, MSB, LSB, FF.
  - Extra rd_req keep returning FF.
  - rd_start and rd_req in the same cycle return status.
